// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM encodings and defaults for the UART TX-side blocks.
package uart_pkg;
  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DONE} state_t;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int LAUNCH_TIMEOUT_DEF = 65535;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first set req searching upward from ptr+1.
module rr_arbiter #(
  parameter int N = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          valid
);
  // Walk from farthest to nearest so the nearest requester after ptr wins last.
  always_comb begin
    grant = '0;
    idx = '0;
    for (int i = N; i >= 1; i--) begin
      if (req[(int'(ptr) + i) % N]) begin
        grant = N'(1) << ((int'(ptr) + i) % N);
        idx = IW'((int'(ptr) + i) % N);
      end
    end
  end
  assign valid = |req;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one UART transmitter among NUM_REQ byte producers.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ID_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  parameter int LAUNCH_TIMEOUT = LAUNCH_TIMEOUT_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          uart_start,
  output logic [DATA_WIDTH-1:0]         uart_data,
  input  logic                          uart_busy,
  output logic [ID_WIDTH-1:0]           grant_id,
  output logic                          arb_busy,
  output logic                          timeout_err
);
  localparam int CW = (LAUNCH_TIMEOUT > 0) ? $clog2(LAUNCH_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'((LAUNCH_TIMEOUT > 0) ? LAUNCH_TIMEOUT - 1 : 0);
  state_t state;
  logic [ID_WIDTH-1:0] rr_ptr, win_id;
  logic [NUM_REQ-1:0] win, gnt_q;
  logic [CW-1:0] cnt;
  logic win_valid;
  rr_arbiter #(.N(NUM_REQ), .IW(ID_WIDTH)) u_rr (
    .req(req),
    .ptr(rr_ptr),
    .grant(win),
    .idx(win_id),
    .valid(win_valid)
  );
  assign arb_busy = state != S_IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      uart_start <= 1'b0;
      uart_data <= '0;
      ack <= '0;
      grant_id <= '0;
      timeout_err <= 1'b0;
      rr_ptr <= ID_WIDTH'(NUM_REQ - 1);
      cnt <= '0;
      gnt_q <= '0;
    end else begin
      ack <= '0;
      timeout_err <= 1'b0;
      case (state)
        S_IDLE: if (win_valid) begin
          state <= S_LAUNCH;
          uart_start <= 1'b1;
          uart_data <= req_data[win_id*DATA_WIDTH +: DATA_WIDTH];
          grant_id <= win_id;
          gnt_q <= win;
          cnt <= '0;
        end
        S_LAUNCH: if (uart_busy) begin
          state <= S_WAIT;
          uart_start <= 1'b0;
        end else if (LAUNCH_TIMEOUT != 0 && cnt == LAST) begin
          state <= S_DONE;
          uart_start <= 1'b0;
          ack <= gnt_q;
          timeout_err <= 1'b1;
        end else if (cnt != '1) begin
          cnt <= cnt + 1'b1;
        end
        S_WAIT: if (!uart_busy) begin
          state <= S_DONE;
          ack <= gnt_q;
        end
        S_DONE: begin
          rr_ptr <= grant_id;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed vector bench with a simple transmitter model.
module tb_uart_tx_arbiter;
  localparam int BUSY_LEN = 40;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req = '0;
  logic [31:0] req_data = '0;
  logic [3:0] ack;
  logic uart_start;
  logic [7:0] uart_data;
  logic uart_busy = 1'b0;
  logic [1:0] grant_id;
  logic arb_busy;
  logic timeout_err;
  logic tx_en = 1'b1;
  int ph = 0, d = 0, start_rises = 0;
  logic [7:0] last_byte = '0;
  int checks = 0, fails = 0;
  int gid_q[$];

  typedef struct {
    int idx;
    logic [7:0] data;
    logic [3:0] exp_ack;
    logic [1:0] exp_gid;
    int exp_start;
  } vec_t;
  vec_t vecs[4];

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .LAUNCH_TIMEOUT(16)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .req_data(req_data),
    .ack(ack),
    .uart_start(uart_start),
    .uart_data(uart_data),
    .uart_busy(uart_busy),
    .grant_id(grant_id),
    .arb_busy(arb_busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Transmitter: busy rises 3 edges after start is first seen, stays high BUSY_LEN edges.
  always @(posedge clk) begin
    if (!tx_en) begin
      uart_busy <= 1'b0;
      ph <= 0;
      d <= 0;
    end else if (ph == 0) begin
      if (uart_start) begin
        ph <= 1;
        d <= 1;
        start_rises <= start_rises + 1;
      end
    end else if (ph == 1) begin
      if (d == 2) begin
        uart_busy <= 1'b1;
        last_byte <= uart_data;
        ph <= 2;
        d <= 0;
      end else d <= d + 1;
    end else begin
      if (d == BUSY_LEN - 1) begin
        uart_busy <= 1'b0;
        ph <= 0;
      end else d <= d + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic single(input vec_t v);
    int cyc, fall, ackc, starts;
    logic seen_busy;
    logic [3:0] got;
    cyc = 0; fall = -1; ackc = -1; starts = 1; seen_busy = 1'b0; got = '0;
    req_data[v.idx*8 +: 8] = v.data;
    req = '0;
    req[v.idx] = 1'b1;
    @(negedge clk);
    chk("start_latency", uart_start, 1);
    chk("grant_id", grant_id, v.exp_gid);
    chk("uart_data", uart_data, v.data);
    chk("arb_busy_launch", arb_busy, 1);
    while (ackc < 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (uart_start) starts++;
      if (uart_busy) seen_busy = 1'b1;
      else if (seen_busy && fall < 0) fall = cyc;
      if (ack != 0) begin
        ackc = cyc;
        got = ack;
        chk("no_timeout_err", timeout_err, 0);
        req = '0;
      end
    end
    chk("start_cycles", starts, v.exp_start);
    chk("ack_value", got, v.exp_ack);
    chk("ack_after_busy_fall", ackc - fall, 1);
    chk("tx_byte", last_byte, v.data);
    @(negedge clk);
    chk("ack_one_cycle", ack, 0);
    chk("arb_idle", arb_busy, 0);
  endtask

  task automatic serve(input int n, input logic [3:0] keep, input int budget);
    int got, cyc;
    got = 0; cyc = 0;
    while (got < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (ack != 0) begin
        chk("ack_matches_grant", ack, 4'b1 << grant_id);
        gid_q.push_back(int'(grant_id));
        req = (req & ~ack) | (keep & ack);
        got++;
      end
    end
    if (got < n) chk("serve_budget", got, n);
  endtask

  initial begin
    int exp_sim[4];
    int exp_fair[4];
    int cyc, acks;
    exp_sim = '{0, 1, 2, 3};
    exp_fair = '{0, 3, 0, 3};
    vecs[0] = '{idx: 2, data: 8'hA5, exp_ack: 4'b0100, exp_gid: 2'd2, exp_start: 4};
    vecs[1] = '{idx: 0, data: 8'h3C, exp_ack: 4'b0001, exp_gid: 2'd0, exp_start: 4};
    vecs[2] = '{idx: 3, data: 8'hFF, exp_ack: 4'b1000, exp_gid: 2'd3, exp_start: 4};
    vecs[3] = '{idx: 1, data: 8'h00, exp_ack: 4'b0010, exp_gid: 2'd1, exp_start: 4};

    do_reset();
    chk("rst_start", uart_start, 0);
    chk("rst_data", uart_data, 0);
    chk("rst_ack", ack, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_busy", arb_busy, 0);
    chk("rst_tmo", timeout_err, 0);

    for (int i = 0; i < 4; i++) single(vecs[i]);

    // Byte in flight must not follow later req_data changes.
    req_data[15:8] = 8'h5A;
    req = 4'b0010;
    cyc = 0;
    while (!(uart_busy && !uart_start) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("stab_reach_wait", cyc < 100, 1);
    req_data[15:8] = 8'hC3;
    cyc = 0;
    while (ack == 0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("stab_ack", ack, 4'b0010);
    chk("stab_uart_data", uart_data, 8'h5A);
    chk("stab_tx_byte", last_byte, 8'h5A);
    req = '0;

    do_reset();
    start_rises = 0;
    gid_q.delete();
    req = 4'b1111;
    serve(4, 4'b0000, 1000);
    for (int i = 0; i < 4; i++) chk("sim_order", (i < gid_q.size()) ? gid_q[i] : -1, exp_sim[i]);
    chk("sim_start_count", start_rises, 4);

    do_reset();
    gid_q.delete();
    req = 4'b1001;
    serve(4, 4'b1001, 1000);
    req = '0;
    for (int i = 0; i < 4; i++) chk("fair_order", (i < gid_q.size()) ? gid_q[i] : -1, exp_fair[i]);
    repeat (3) @(negedge clk);

    tx_en = 1'b0;
    do_reset();
    req = 4'b0010;
    cyc = 0;
    acks = 0;
    while (ack == 0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (uart_start) acks++;
    end
    chk("tmo_start_cycles", acks, 16);
    chk("tmo_ack", ack, 4'b0010);
    chk("tmo_err", timeout_err, 1);
    req = '0;
    @(negedge clk);
    chk("tmo_err_pulse", timeout_err, 0);
    chk("tmo_idle", arb_busy, 0);
    tx_en = 1'b1;

    do_reset();
    req = 4'b0100;
    cyc = 0;
    while (!(uart_busy && !uart_start) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("rstmid_reach_wait", cyc < 100, 1);
    chk("rstmid_gid_before", grant_id, 2);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    chk("rstmid_start", uart_start, 0);
    chk("rstmid_ack", ack, 0);
    chk("rstmid_busy", arb_busy, 0);
    chk("rstmid_gid", grant_id, 0);
    rst = 1'b0;
    acks = 0;
    repeat (BUSY_LEN + 5) begin
      @(negedge clk);
      if (ack != 0) acks++;
    end
    chk("rstmid_no_ack", acks, 0);
    single('{idx: 0, data: 8'h77, exp_ack: 4'b0001, exp_gid: 2'd0, exp_start: 4});

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end
endmodule
